// File: rtl/mem_port_arbiter.sv
// Shares one OBI memory port between the core instruction and data masters.
// Requests are granted round-robin; responses return in order via a 1-bit owner FIFO.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  input  logic          data_req_i,
  input  logic [31:0]   data_addr_i,
  input  logic [3:0]    data_be_i,
  input  logic          data_we_i,
  input  logic [31:0]   data_wdata_i,
  output logic          data_gnt_o,
  output logic          data_rvalid_o,
  output logic [31:0]   data_rdata_o,
  output logic          mem_req_o,
  output logic [31:0]   mem_addr_o,
  output logic [3:0]    mem_be_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_wdata_o,
  input  logic          mem_gnt_i,
  input  logic          mem_rvalid_i,
  input  logic [31:0]   mem_rdata_i,
  output logic          dbg_state_o,
  output logic [CW-1:0] dbg_cnt_o
);

  // Handshake: a transfer happens on a cycle where mem_req_o && mem_gnt_i;
  // once mem_req_o is raised it stays high (same master) until granted.
  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                     state_q, state_d;
  logic                       own_q, own_d;
  logic                       last_q;
  logic [CW-1:0]              cnt_q;
  logic [PW-1:0]              wptr_q, rptr_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;

  logic has_req, chosen, pending, grant, pop, head;

  always_comb begin
    has_req = 1'b0;
    chosen  = 1'b0;
    state_d = state_q;
    own_d   = own_q;
    case (state_q)
      IDLE: begin
        has_req = instr_req_i | data_req_i;
        // On a tie the master that was not granted last wins.
        if (instr_req_i && data_req_i) chosen = ~last_q;
        else                           chosen = data_req_i;
      end
      LOCKED: begin
        has_req = 1'b1;
        chosen  = own_q;
      end
      default: ;
    endcase

    pending = has_req && (cnt_q < CW'(MAX_OUTSTANDING));
    grant   = pending && mem_gnt_i && !rst_i;

    case (state_q)
      IDLE: if (pending && !mem_gnt_i) begin
        state_d = LOCKED;
        own_d   = chosen;
      end
      LOCKED: if (grant) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o   = pending && !rst_i;
  assign mem_addr_o  = chosen ? data_addr_i  : instr_addr_i;
  assign mem_be_o    = chosen ? data_be_i    : 4'hF;
  assign mem_we_o    = chosen ? data_we_i    : 1'b0;
  assign mem_wdata_o = chosen ? data_wdata_i : 32'h0;

  assign instr_gnt_o = grant && !chosen;
  assign data_gnt_o  = grant &&  chosen;

  // Stray responses with nothing outstanding are dropped.
  assign pop            = mem_rvalid_i && (cnt_q != '0) && !rst_i;
  assign head           = fifo_q[rptr_q];
  assign instr_rvalid_o = pop && !head;
  assign data_rvalid_o  = pop &&  head;
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  assign dbg_state_o = (state_q == LOCKED);
  assign dbg_cnt_o   = cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fifo_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      if (grant) begin
        last_q         <= chosen;
        fifo_q[wptr_q] <= chosen;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
      if (grant && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (!grant && pop) cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid;
  logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic [3:0]  data_be;
  logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
  logic [31:0] instr_rdata, data_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        dbg_state;
  logic [1:0]  dbg_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_be_i(data_be),
    .data_we_i(data_we), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
    .mem_rdata_i(mem_rdata), .dbg_state_o(dbg_state), .dbg_cnt_o(dbg_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: owners of outstanding transactions, who won last, and
  // which master (if any) has been presented to memory without a grant yet.
  int mq[$];
  int last_m   = 0;
  int commit_m = -1;
  bit m_gi, m_gd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic model_and_advance();
    int  ch;
    bit  has, pend, gnt, pop;
    int  head;
    m_gi = 0;
    m_gd = 0;
    if (rst) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_instr_gnt", instr_gnt, 0);
      chk("rst_data_gnt", data_gnt, 0);
      chk("rst_instr_rvalid", instr_rvalid, 0);
      chk("rst_data_rvalid", data_rvalid, 0);
      chk("rst_cnt", dbg_cnt, 0);
      mq.delete();
      last_m   = 0;
      commit_m = -1;
    end else begin
      has = 1;
      if (commit_m >= 0)                ch = commit_m;
      else if (instr_req && data_req)   ch = 1 - last_m;
      else if (data_req)                ch = 1;
      else if (instr_req)               ch = 0;
      else begin has = 0; ch = 0; end
      pend = has && (mq.size() < MAXO);
      gnt  = pend && mem_gnt;
      pop  = mem_rvalid && (mq.size() > 0);
      head = pop ? mq[0] : 0;
      chk("mem_req", mem_req, pend);
      chk("instr_gnt", instr_gnt, gnt && ch == 0);
      chk("data_gnt", data_gnt, gnt && ch == 1);
      chk("instr_rvalid", instr_rvalid, pop && head == 0);
      chk("data_rvalid", data_rvalid, pop && head == 1);
      chk("instr_rdata", instr_rdata, mem_rdata);
      chk("data_rdata", data_rdata, mem_rdata);
      chk("cnt", dbg_cnt, mq.size());
      if (pend) begin
        chk("mem_addr", mem_addr, ch ? data_addr : instr_addr);
        chk("mem_be", mem_be, ch ? data_be : 4'hF);
        chk("mem_we", mem_we, ch ? data_we : 1'b0);
        chk("mem_wdata", mem_wdata, ch ? data_wdata : 32'h0);
      end
      if (pop) void'(mq.pop_front());
      if (gnt) begin
        mq.push_back(ch);
        last_m   = ch;
        commit_m = -1;
        m_gi     = (ch == 0);
        m_gd     = (ch == 1);
      end else if (pend) begin
        commit_m = ch;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    settle();
    model_and_advance();
  endtask

  task automatic idle_inputs();
    instr_req  = 0;
    data_req   = 0;
    mem_gnt    = 0;
    mem_rvalid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    step();
    rst = 0;
  endtask

  task automatic drain();
    idle_inputs();
    mem_rvalid = 1;
    for (int i = 0; i < MAXO + 1; i++) step();
    mem_rvalid = 0;
  endtask

  task automatic drive_random();
    if (!(instr_req && !m_gi)) begin
      instr_req  = ($urandom_range(0, 2) != 0);
      instr_addr = $urandom;
    end
    if (!(data_req && !m_gd)) begin
      data_req   = ($urandom_range(0, 2) != 0);
      data_addr  = $urandom;
      data_be    = 4'($urandom_range(0, 15));
      data_we    = 1'($urandom_range(0, 1));
      data_wdata = $urandom;
    end
    mem_gnt    = ($urandom_range(0, 2) != 0);
    mem_rvalid = ($urandom_range(0, 1) != 0);
    mem_rdata  = $urandom;
    rst        = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    bit seq[6];
    bit prev;
    rst        = 1;
    idle_inputs();
    instr_addr = 32'h0000_1000;
    data_addr  = 32'h0000_2000;
    data_be    = 4'h3;
    data_we    = 1;
    data_wdata = 32'hCAFE_F00D;
    mem_rdata  = 32'h1234_5678;
    @(posedge clk);
    #1;

    // Reset holds everything quiet even with requests and grants present.
    instr_req = 1;
    data_req  = 1;
    mem_gnt   = 1;
    step();
    rst = 0;

    // Tie from reset with grant every cycle: data, instr, data, instr.
    instr_req = 1;
    data_req  = 1;
    mem_gnt   = 1;
    for (int k = 0; k < 6; k++) begin
      mem_rvalid = (k > 0);
      settle();
      chk("alt_data_gnt", data_gnt, (k % 2) == 0);
      chk("alt_instr_gnt", instr_gnt, (k % 2) == 1);
      if (k > 0) chk("alt_data_rvalid", data_rvalid, ((k - 1) % 2) == 0);
      model_and_advance();
    end
    drain();

    // Locked to instr while memory stalls; data arriving late is ignored.
    do_reset();
    instr_req = 1;
    for (int k = 1; k <= 4; k++) begin
      if (k >= 2) data_req = 1;
      mem_gnt = (k == 4);
      settle();
      chk("lock_addr", mem_addr, 32'h0000_1000);
      chk("lock_be", mem_be, 4'hF);
      if (k == 4) begin
        chk("lock_instr_gnt", instr_gnt, 1);
        chk("lock_data_gnt", data_gnt, 0);
      end
      model_and_advance();
    end
    drain();

    // Outstanding limit: two grants, then blocked until one response retires.
    do_reset();
    instr_req = 1;
    mem_gnt   = 1;
    for (int k = 1; k <= 6; k++) begin
      mem_rvalid = (k == 5);
      settle();
      case (k)
        1, 2: chk("lim_grant", instr_gnt, 1);
        3, 4: chk("lim_blocked", mem_req, 0);
        5: begin
          chk("lim_blocked_on_pop", mem_req, 0);
          chk("lim_rvalid", instr_rvalid, 1);
        end
        default: chk("lim_reopen", instr_gnt, 1);
      endcase
      model_and_advance();
    end
    drain();

    // Push and pop together keep the count at one and preserve order.
    do_reset();
    data_req = 1;
    mem_gnt  = 1;
    step();
    seq  = '{0, 1, 1, 0, 1, 0};
    prev = 1;
    for (int k = 0; k < 6; k++) begin
      instr_req  = !seq[k];
      data_req   = seq[k];
      mem_rvalid = 1;
      settle();
      chk("pp_cnt", dbg_cnt, 1);
      chk("pp_data_rvalid", data_rvalid, prev);
      chk("pp_instr_rvalid", instr_rvalid, !prev);
      chk("pp_data_gnt", data_gnt, seq[k]);
      model_and_advance();
      prev = seq[k];
    end
    idle_inputs();
    mem_rvalid = 1;
    settle();
    chk("pp_last_rvalid", data_rvalid, prev);
    model_and_advance();
    settle();
    chk("pp_empty_cnt", dbg_cnt, 0);
    model_and_advance();
    mem_rvalid = 0;

    // Reset with two outstanding; stray responses afterwards are dropped.
    do_reset();
    instr_req = 1;
    mem_gnt   = 1;
    step();
    step();
    idle_inputs();
    settle();
    chk("rs_cnt_before", dbg_cnt, 2);
    model_and_advance();
    do_reset();
    mem_rvalid = 1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("rs_stray_instr", instr_rvalid, 0);
      chk("rs_stray_data", data_rvalid, 0);
      chk("rs_cnt", dbg_cnt, 0);
      model_and_advance();
    end
    mem_rvalid = 0;
    instr_req  = 1;
    data_req   = 1;
    mem_gnt    = 1;
    settle();
    chk("rs_tie_data", data_gnt, 1);
    chk("rs_tie_instr", instr_gnt, 0);
    model_and_advance();
    drain();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive_random();
      step();
    end
    rst = 0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, meaning the maximum number of granted transactions awaiting rvalid (legal range 1..4).
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports instr_req_i input 1, instr_addr_i input 32, instr_gnt_o output 1, instr_rvalid_o output 1, instr_rdata_o output 32: the core instruction OBI port (read-only).
REQ-005 SHALL have ports data_req_i input 1, data_addr_i input 32, data_be_i input 4, data_we_i input 1, data_wdata_i input 32, data_gnt_o output 1, data_rvalid_o output 1, data_rdata_o output 32: the core data OBI port.
REQ-006 SHALL have ports mem_req_o output 1, mem_addr_o output 32, mem_be_o output 4, mem_we_o output 1, mem_wdata_o output 32, mem_gnt_i input 1, mem_rvalid_i input 1, mem_rdata_i input 32: the shared memory OBI port.

Function
REQ-007 SHALL share the mem port between the instr and data masters, with in-order responses.
REQ-008 SHALL implement states IDLE and LOCKED; LOCKED holds owner register own (0 = instr, 1 = data).
REQ-009 IDLE: requester is the one asserting req; if both assert, round-robin picks the master not granted last (pointer last, reset value instr, so data wins the first tie).
REQ-010 mem_req_o SHALL be 1 only when a requester exists and outstanding count cnt < MAX_OUTSTANDING; the pending flag used in REQ-013 is the AND of these two conditions.
REQ-011 mem_addr_o/be/we/wdata SHALL be driven combinationally from the chosen master; the instr source gives be = 4'hF, we = 0, wdata = 0.
REQ-012 A grant occurs when mem_req_o && mem_gnt_i; in that cycle the owner's gnt_o = 1 and every other gnt_o = 0, the owner id is pushed into the response FIFO, and last = owner.
REQ-013 IDLE with req pending but no mem_gnt_i SHALL go to LOCKED with own = chosen master.
REQ-014 LOCKED SHALL present only own to the mem port, ignore the other master, and return to IDLE on a grant.
REQ-015 LOCKED SHALL keep mem_req_o = 1 even if the owner deasserts req (OBI forbids retraction); core masters are not expected to do this.
REQ-016 The response FIFO SHALL be MAX_OUTSTANDING deep, 1 bit wide, with count cnt of width $clog2(MAX_OUTSTANDING+1).
REQ-017 When mem_rvalid_i = 1, the FIFO head SHALL be popped and that master's rvalid_o set to 1 in the same cycle, combinationally.
REQ-018 instr_rdata_o and data_rdata_o SHALL both carry mem_rdata_i at all times.
REQ-019 A simultaneous push and pop SHALL leave cnt unchanged.
REQ-020 The admission check uses the registered cnt: when cnt = MAX_OUTSTANDING, mem_req_o = 0 even if an rvalid pops in that cycle.
REQ-021 mem_rvalid_i with cnt = 0 SHALL be ignored: no rvalid_o asserted and cnt unchanged.
REQ-022 The FIFO read and write pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-023 gnt_o and rvalid_o SHALL never be asserted to a master that did not win the grant or own the response.

Reset
REQ-024 Asserting rst_i SHALL immediately set state IDLE, own = 0, last = instr, cnt = 0 and both FIFO pointers 0.
REQ-025 While rst_i = 1, all gnt_o, all rvalid_o and mem_req_o SHALL be 0.
REQ-026 Reset mid-transaction SHALL discard outstanding entries; later stray mem_rvalid_i is then ignored per REQ-021.
REQ-027 Deasserting rst_i SHALL allow operation from the first following clock edge.

Verification
REQ-028 Both reqs high from reset, mem_gnt_i = 1 every cycle, rvalid 1 cycle after gnt -> grants alternate data, instr, data, instr; each rvalid_o goes to the matching master.
REQ-029 instr_req_i high, mem_gnt_i = 0 for 3 cycles, data_req_i rises in cycle 2 -> mem_addr_o stays at instr_addr_i; at the 4th-cycle grant instr_gnt_o = 1 and data_gnt_o = 0.
REQ-030 MAX_OUTSTANDING = 2, no rvalid, 3 grantable requests -> 2 grants, then mem_req_o = 0 until an rvalid, then 1 on the next cycle.
REQ-031 cnt = 1 with grant and rvalid in the same cycle -> cnt stays 1 and FIFO order is preserved over 6 mixed transactions.
REQ-032 rst_i pulsed with 2 outstanding, then 2 stray mem_rvalid_i -> no rvalid_o asserted, cnt = 0, and the next tie is granted to data.
